wb_trace_tx: RTL and testbench
==============================

WB_TRACE_TX -- requirements
Module: wb_trace_tx

Interface
REQ-001 Parameter FIFO_DEPTH, 8, number of buffered writeback events; power of two, 2..64.
REQ-002 Parameter TRACE_ZERO, 0, 1 = also trace writes to register 0.
REQ-003 The port clk SHALL be input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The port rst_n SHALL be input, 1 bit, the reset: synchronous and active-low.
REQ-005 The port wb_reg_write SHALL be input, 1 bit, high when the WB stage commits a register write this cycle.
REQ-006 The port wb_dest SHALL be input, 5 bits, the destination register index.
REQ-007 The port wb_data SHALL be input, 32 bits, the write data.
REQ-008 The port wb_pc SHALL be input, 32 bits, the PC of the committing instruction.
REQ-009 The port trace_valid SHALL be output, 1 bit, marking a trace word available.
REQ-010 The port trace_data SHALL be output, 32 bits, the trace word.
REQ-011 The port trace_ready SHALL be input, 1 bit, the consumer accept.
REQ-012 The port drop_cnt SHALL be output, 8 bits, the total dropped events, saturating.
REQ-013 The port fifo_level SHALL be output, $clog2(FIFO_DEPTH)+1 bits, the current occupancy.

Function
REQ-014 Capture: an event SHALL be pushed on an edge where wb_reg_write=1 and (wb_dest!=0 or TRACE_ZERO=1); it records {dest, data, pc, cycle_cnt[15:0]}.
REQ-015 cycle_cnt SHALL be a 32-bit free-running counter, incremented every cycle and wrapping at 2^32.
REQ-016 Each event SHALL serialize to words in this fixed order: HDR, DATA (wb_data), PC (wb_pc).
REQ-017 The HDR word SHALL be: [31:24]=8'hA5, [23:19]=dest, [18]=ovf, [17:16]=0, [15:0]=cycle stamp.
REQ-018 FSM states SHALL be IDLE, HDR, DATA, PC. Transitions:
- IDLE->HDR when the FIFO is non-empty.
- HDR->DATA on handshake.
- DATA->PC on handshake.
- PC->HDR on handshake if the FIFO is non-empty after the pop, else PC->IDLE.
REQ-019 The FIFO entry SHALL pop on the PC-word handshake.
REQ-020 A transfer SHALL occur on an edge with trace_valid=1 and trace_ready=1; while valid and not ready, trace_data is held stable and valid stays high.
REQ-021 trace_valid SHALL be 1 exactly in states HDR/DATA/PC, and 0 in IDLE.
REQ-022 Latency: an event captured at edge N into an empty FIFO in IDLE SHALL give trace_valid=1 with HDR after edge N+1.
REQ-023 With trace_ready held high, one event SHALL take exactly 3 cycles, and back-to-back events SHALL have no idle gap.
REQ-024 FIFO full with no pop on the same edge: the event SHALL be dropped, drop_cnt increments (saturating at 255), and the sticky ovf flag is set.
REQ-025 FIFO full with a PC-word pop on the same edge: the push SHALL be accepted and nothing dropped.
REQ-026 ovf SHALL be sampled into the HDR of the next event leaving IDLE or PC, then cleared; a drop on that same edge re-sets it.
REQ-027 fifo_level SHALL update on the same edge as the push/pop.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set: state=IDLE, FIFO empty, trace_valid=0, trace_data=0, drop_cnt=0, ovf=0, cycle_cnt=0, fifo_level=0.
REQ-029 Reset mid-event SHALL abort the serialization; the partial event is not resumed, and no capture occurs while rst_n=0.

Configuration
REQ-030 Macro WB_TRACE_PC_WORD_EN, defined: the PC word SHALL be emitted (3 words/event), and pc is stored in the FIFO.
REQ-031 WB_TRACE_PC_WORD_EN undefined: the PC state and pc storage SHALL be removed; the pop occurs on the DATA handshake, at 2 words/event; DATA goes to HDR or IDLE.

Structure
REQ-032 The shared package SHALL hold the state enum, the HDR sync constant 8'hA5, and the HDR field bit positions.
REQ-033 The FIFO SHALL be a sub-module wb_trace_fifo: synchronous, single clock, with full/empty/level outputs.

Verification
REQ-034 Single event, ready=1: dest=9, data=2, pc=228, captured at cycle 5. Required words: 0xA5480005, 0x00000002, 0x000000E4, valid for 3 cycles, then IDLE.
REQ-035 wb_dest=0 with TRACE_ZERO=0: no output and fifo_level stays 0. With TRACE_ZERO=1: an event is emitted with HDR[23:19]=0.
REQ-036 ready=0, 10 events at FIFO_DEPTH=8: fifo_level=8 and drop_cnt=2. After ready=1, the first HDR has bit18=0 (it was pushed before the drop), and ovf is set on the HDR of the next event to leave IDLE or PC after the drops.
REQ-037 Backpressure: toggle ready every cycle; trace_data is stable whenever valid and not ready, and word order is intact.
REQ-038 FIFO full with a simultaneous PC-word pop and new capture: drop_cnt is unchanged and the level stays 8.
REQ-039 rst_n low during the DATA word: the next cycle has trace_valid=0, fifo_level=0, drop_cnt=0, and the following capture's stamp restarts from 0.

Source files
------------

// File: rtl/wb_trace_tx_pkg.sv
// Shared types and constants for the writeback trace transmitter.
// WB_TRACE_PC_WORD_EN adds the PC word (and PC storage) to each event.
package wb_trace_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
`ifdef WB_TRACE_PC_WORD_EN
      , ST_PC = 2'd3
`endif
   } trace_state_e;

   localparam logic [7:0] HDR_SYNC      = 8'hA5;
   localparam int         HDR_SYNC_LSB  = 24;
   localparam int         HDR_DEST_LSB  = 19;
   localparam int         HDR_OVF_BIT   = 18;
   localparam int         HDR_STAMP_LSB = 0;

   typedef struct packed {
      logic [4:0]  dest;
      logic [31:0] data;
`ifdef WB_TRACE_PC_WORD_EN
      logic [31:0] pc;
`endif
      logic [15:0] stamp;
   } trace_evt_t;

   function automatic logic [31:0] build_hdr(input logic [4:0]  dest,
                                             input logic        ovf,
                                             input logic [15:0] stamp);
      logic [31:0] w;
      w                          = 32'd0;
      w[HDR_SYNC_LSB +: 8]       = HDR_SYNC;
      w[HDR_DEST_LSB +: 5]       = dest;
      w[HDR_OVF_BIT]             = ovf;
      w[HDR_STAMP_LSB +: 16]     = stamp;
      return w;
   endfunction

endpackage

// File: rtl/wb_trace_tx_if.sv
// Writeback capture and trace stream signals of the trace transmitter.
// WB_TRACE_PC_WORD_EN does not change the signal set; wb_pc is always present.
interface wb_trace_if;
   logic        wb_reg_write;
   logic [4:0]  wb_dest;
   logic [31:0] wb_data;
   logic [31:0] wb_pc;
   logic        trace_valid;
   logic [31:0] trace_data;
   logic        trace_ready;

   modport master (
      output wb_reg_write, wb_dest, wb_data, wb_pc, trace_ready,
      input  trace_valid, trace_data
   );

   modport slave (
      input  wb_reg_write, wb_dest, wb_data, wb_pc, trace_ready,
      output trace_valid, trace_data
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// Single-clock event FIFO with first-word-fall-through head and occupancy.
// Entry layout follows trace_evt_t, so WB_TRACE_PC_WORD_EN sets its width.
module wb_trace_fifo
   import wb_trace_tx_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  trace_evt_t               push_data_i,
   input  logic                     pop_i,
   output trace_evt_t               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   trace_evt_t          mem_q [DEPTH];
   logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0]       lvl_q, lvl_d;
   logic                do_push_s, do_pop_s;

   assign full_o    = (lvl_q == FULL_LVL);
   assign empty_o   = (lvl_q == {LW{1'b0}});
   assign level_o   = lvl_q;
   assign head_o    = mem_q[rd_q];
   // A full FIFO may still accept a write when the head leaves on the same edge.
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);

   // Pointer and occupancy next-state.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      lvl_d = lvl_q;
      if (do_push_s) begin
         wr_d = wr_q + AW'(1);
      end else begin
         wr_d = wr_q;
      end
      if (do_pop_s) begin
         rd_d = rd_q + AW'(1);
      end else begin
         rd_d = rd_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   lvl_d = lvl_q + LW'(1);
         2'b01:   lvl_d = lvl_q - LW'(1);
         default: lvl_d = lvl_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= {AW{1'b0}};
         rd_q  <= {AW{1'b0}};
         lvl_q <= {LW{1'b0}};
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         lvl_q <= lvl_d;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/wb_trace_tx.sv
// Captures register writebacks into a FIFO and serialises each as HDR, DATA
// (and PC when WB_TRACE_PC_WORD_EN is defined) words on a valid/ready stream.
module wb_trace_tx
   import wb_trace_tx_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter bit TRACE_ZERO = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   wb_trace_if.slave                     bus,
   output logic [7:0]                    drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef WB_TRACE_PC_WORD_EN
   localparam trace_state_e ST_LAST = ST_PC;
`else
   localparam trace_state_e ST_LAST = ST_DATA;
`endif

   trace_state_e   state_q, state_d;
   logic           ovf_q, ovf_d, hdr_ovf_q, hdr_ovf_d;
   logic [7:0]     drop_q, drop_d;
   logic [31:0]    cyc_q, cyc_d;
   trace_evt_t     evt_s, head_s;
   logic           full_s, empty_s;
   logic [LW-1:0]  level_s;
   logic           cap_s, hs_s, pop_s, push_s, drop_s, more_s, load_hdr_s;

   assign cap_s  = rst_n && bus.wb_reg_write &&
                   ((bus.wb_dest != 5'd0) || (TRACE_ZERO == 1'b1));
   assign hs_s   = bus.trace_valid && bus.trace_ready;
   assign pop_s  = hs_s && (state_q == ST_LAST);
   assign push_s = cap_s && (!full_s || pop_s);
   assign drop_s = cap_s && full_s && !pop_s;
   // Another event is ready to follow if one stays queued or arrives on the pop edge.
   assign more_s = (level_s > LW'(1)) || push_s;

   // Event record assembled from the committing instruction.
   always_comb begin
      evt_s       = '0;
      evt_s.dest  = bus.wb_dest;
      evt_s.data  = bus.wb_data;
`ifdef WB_TRACE_PC_WORD_EN
      evt_s.pc    = bus.wb_pc;
`endif
      evt_s.stamp = cyc_q[15:0];
   end

`ifndef WB_TRACE_PC_WORD_EN
   logic unused_pc_s;
   assign unused_pc_s = ^bus.wb_pc;
`endif

   wb_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_s),
      .push_data_i (evt_s),
      .pop_i       (pop_s),
      .head_o      (head_s),
      .full_o      (full_s),
      .empty_o     (empty_s),
      .level_o     (level_s)
   );

   // Serialiser next state.
   always_comb begin
      state_d    = state_q;
      load_hdr_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty_s) begin
               state_d    = ST_HDR;
               load_hdr_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (hs_s) state_d = ST_DATA;
            else      state_d = ST_HDR;
         end
`ifdef WB_TRACE_PC_WORD_EN
         ST_DATA: begin
            if (hs_s) state_d = ST_PC;
            else      state_d = ST_DATA;
         end
`endif
         ST_LAST: begin
            if (hs_s && more_s) begin
               state_d    = ST_HDR;
               load_hdr_s = 1'b1;
            end else if (hs_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LAST;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Overflow flag, drop counter and cycle counter next state.
   always_comb begin
      cyc_d     = cyc_q + 32'd1;
      hdr_ovf_d = hdr_ovf_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      if (load_hdr_s) begin
         hdr_ovf_d = ovf_q;
      end else begin
         hdr_ovf_d = hdr_ovf_q;
      end
      // A drop on the sampling edge wins over the clear so it is never lost.
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (load_hdr_s) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
      if (drop_s && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ovf_q     <= 1'b0;
         hdr_ovf_q <= 1'b0;
         drop_q    <= 8'd0;
         cyc_q     <= 32'd0;
      end else begin
         state_q   <= state_d;
         ovf_q     <= ovf_d;
         hdr_ovf_q <= hdr_ovf_d;
         drop_q    <= drop_d;
         cyc_q     <= cyc_d;
      end
   end

   // Output word selected from the FIFO head; stable while the state holds.
   always_comb begin
      bus.trace_data = 32'd0;
      case (state_q)
         ST_HDR:  bus.trace_data = build_hdr(head_s.dest, hdr_ovf_q, head_s.stamp);
         ST_DATA: bus.trace_data = head_s.data;
`ifdef WB_TRACE_PC_WORD_EN
         ST_PC:   bus.trace_data = head_s.pc;
`endif
         default: bus.trace_data = 32'd0;
      endcase
   end

   assign bus.trace_valid = (state_q != ST_IDLE);
   assign drop_cnt        = drop_q;
   assign fifo_level      = level_s;

endmodule

// File: tb/tb_wb_trace_tx.sv
// Scoreboard bench for wb_trace_tx; word count follows WB_TRACE_PC_WORD_EN.
module tb_wb_trace_tx;
`ifdef WB_TRACE_PC_WORD_EN
   localparam int W = 3;
`else
   localparam int W = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  drop_cnt, zdrop;
   logic [3:0]  fifo_level, zlevel;
   logic [31:0] tb_cyc = 32'd0;
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   wb_trace_if bus();
   wb_trace_if zbus();

   assign zbus.wb_reg_write = bus.wb_reg_write;
   assign zbus.wb_dest      = bus.wb_dest;
   assign zbus.wb_data      = bus.wb_data;
   assign zbus.wb_pc        = bus.wb_pc;
   assign zbus.trace_ready  = 1'b1;

   wb_trace_tx #(.FIFO_DEPTH(8), .TRACE_ZERO(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .drop_cnt(drop_cnt), .fifo_level(fifo_level));
   wb_trace_tx #(.FIFO_DEPTH(8), .TRACE_ZERO(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .bus(zbus), .drop_cnt(zdrop), .fifo_level(zlevel));

   // Reference cycle counter: cleared by reset, +1 every other edge.
   always @(posedge clk) tb_cyc <= (!rst_n) ? 32'd0 : tb_cyc + 32'd1;

   // Words presented with valid & ready transfer on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && bus.trace_valid && bus.trace_ready) obs_q.push_back(bus.trace_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_evt(input logic [4:0] d, input logic [31:0] dat, input logic [31:0] pc,
                            input bit exp_en, input bit exp_ovf);
      bus.wb_reg_write = 1'b1;
      bus.wb_dest      = d;
      bus.wb_data      = dat;
      bus.wb_pc        = pc;
      if (exp_en) begin
         exp_q.push_back({8'hA5, d, exp_ovf, 2'b00, tb_cyc[15:0]});
         exp_q.push_back(dat);
`ifdef WB_TRACE_PC_WORD_EN
         exp_q.push_back(pc);
`endif
      end
      tick();
      bus.wb_reg_write = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400 && obs_q.size() < exp_q.size(); i++) tick();
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.trace_ready  = 1'b1;
      bus.wb_reg_write = 1'b1;
      bus.wb_dest      = 5'd3;
      bus.wb_data      = 32'h1;
      bus.wb_pc        = 32'h4;
      repeat (3) tick();
      checks += 4;
      if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.trace_valid); end
      if (bus.trace_data !== 32'd0) begin failures++; $display("FAIL reset_data: got %h want 0", bus.trace_data); end
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
      if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      bus.wb_reg_write = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] e, o;
      int nv;
      bus.trace_ready = 1'b1;
      for (int i = 0; i < 50 && tb_cyc != 32'd5; i++) tick();
      drive_evt(5'd9, 32'd2, 32'd228, 1'b1, 1'b0);
      checks += 2;
      if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid: got %b want 0", bus.trace_valid); end
      if (fifo_level !== 4'd1) begin failures++; $display("FAIL single_level: got %0d want 1", fifo_level); end
      tick();
      checks += 2;
      if (bus.trace_valid !== 1'b1) begin failures++; $display("FAIL single_latency: got %b want 1", bus.trace_valid); end
      if (bus.trace_data !== 32'hA5480005) begin failures++; $display("FAIL single_hdr: got %h want a5480005", bus.trace_data); end
      nv = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.trace_valid) nv++;
      end
      checks += 2;
      if (nv != W) begin failures++; $display("FAIL single_valid_cycles: got %0d want %0d", nv, W); end
      if (bus.trace_valid !== 1'b0 || fifo_level !== 4'd0) begin
         failures++; $display("FAIL single_idle: got valid=%b level=%0d want 0/0", bus.trace_valid, fifo_level);
      end
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL single_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_zero();
      logic [15:0] zstamp;
      logic [31:0] zhdr;
      bit zseen;
      zstamp = tb_cyc[15:0];
      zseen  = 1'b0;
      zhdr   = 32'd0;
      drive_evt(5'd0, 32'h1234, 32'h40, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (zbus.trace_valid && !zseen) begin zseen = 1'b1; zhdr = zbus.trace_data; end
         checks++;
         if (fifo_level !== 4'd0 || bus.trace_valid !== 1'b0) begin
            failures++; $display("FAIL zero_ignored: got level=%0d valid=%b want 0/0", fifo_level, bus.trace_valid);
         end
         tick();
      end
      checks += 2;
      if (!zseen) begin failures++; $display("FAIL zero_traced: got no event want one"); end
      if (zhdr !== {8'hA5, 5'd0, 1'b0, 2'b00, zstamp}) begin
         failures++; $display("FAIL zero_hdr: got %h want %h", zhdr, {8'hA5, 5'd0, 1'b0, 2'b00, zstamp});
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e, o;
      int nv, first, last;
      nv = 0; first = -1; last = -1;
      bus.trace_ready = 1'b1;
      for (int i = 0; i < 4 * W + 8; i++) begin
         if (i < 4) drive_evt(5'(i + 1), 32'h1000 + i, 32'h2000 + 4 * i, 1'b1, 1'b0);
         else tick();
         if (bus.trace_valid) begin
            nv++;
            if (first < 0) first = i;
            last = i;
         end
      end
      checks += 2;
      if (nv != 4 * W) begin failures++; $display("FAIL b2b_valid_cycles: got %0d want %0d", nv, 4 * W); end
      if (last - first + 1 != 4 * W) begin failures++; $display("FAIL b2b_gap: got span %0d want %0d", last - first + 1, 4 * W); end
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL b2b_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_backpressure();
      logic [31:0] e, o, pd;
      logic pv, pr;
      for (int i = 0; i < 60; i++) begin
         bus.trace_ready = i[0];
         pv = bus.trace_valid; pr = bus.trace_ready; pd = bus.trace_data;
         if (i < 3) drive_evt(5'(20 + i), 32'hB000 + i, 32'h3000 + 4 * i, 1'b1, 1'b0);
         else tick();
         if (pv && !pr) begin
            checks++;
            if (bus.trace_valid !== 1'b1 || bus.trace_data !== pd) begin
               failures++; $display("FAIL bp_hold: got valid=%b data=%h want 1/%h", bus.trace_valid, bus.trace_data, pd);
            end
         end
      end
      bus.trace_ready = 1'b1;
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL bp_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overflow(input int n, input logic [7:0] exp_drop);
      logic [31:0] e, o;
      bus.trace_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
         drive_evt(5'd7, 32'hC0000000 + k, 32'h8000 + 4 * k, (k < 8), (k == 1));
      end
      checks += 2;
      if (fifo_level !== 4'd8) begin failures++; $display("FAIL ovf_level: got %0d want 8", fifo_level); end
      if (drop_cnt !== exp_drop) begin failures++; $display("FAIL ovf_drop: got %0d want %0d", drop_cnt, exp_drop); end
      bus.trace_ready = 1'b1;
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL ovf_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_full_pop();
      logic [31:0] e, o;
      logic [7:0] base;
      base = drop_cnt;
      bus.trace_ready = 1'b0;
      for (int k = 0; k < 8; k++) drive_evt(5'd17, 32'hE000 + k, 32'h500 + 4 * k, 1'b1, 1'b0);
      checks++;
      if (fifo_level !== 4'd8) begin failures++; $display("FAIL fullpop_fill: got %0d want 8", fifo_level); end
      bus.trace_ready = 1'b1;
      repeat (W - 1) tick();
      drive_evt(5'd21, 32'hF00D, 32'h1F0, 1'b1, 1'b0);
      checks += 2;
      if (fifo_level !== 4'd8) begin failures++; $display("FAIL fullpop_level: got %0d want 8", fifo_level); end
      if (drop_cnt !== base) begin failures++; $display("FAIL fullpop_drop: got %0d want %0d", drop_cnt, base); end
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL fullpop_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL fullpop_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid();
      logic [31:0] e, o;
      bit found;
      found = 1'b0;
      bus.trace_ready = 1'b1;
      drive_evt(5'd12, 32'hDEAD0001, 32'h300, 1'b1, 1'b0);
      for (int i = 0; i < 10 && !found; i++) begin
         if (bus.trace_valid && bus.trace_data == 32'hDEAD0001) found = 1'b1;
         else tick();
      end
      checks++;
      if (!found) begin failures++; $display("FAIL rstmid_data_word: got none want DATA word presented"); end
      rst_n = 1'b0;
      bus.trace_ready = 1'b0;
      tick();
      checks += 3;
      if (bus.trace_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid: got %b want 0", bus.trace_valid); end
      if (fifo_level !== 4'd0) begin failures++; $display("FAIL rstmid_level: got %0d want 0", fifo_level); end
      if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_drop: got %0d want 0", drop_cnt); end
      checks++;
      if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         failures++; $display("FAIL rstmid_hdr: got %0d words want 1 matching %h", obs_q.size(), exp_q[0]);
      end
      exp_q.delete(); obs_q.delete();
      rst_n = 1'b1;
      bus.trace_ready = 1'b1;
      exp_q.push_back({8'hA5, 5'd12, 1'b0, 2'b00, 16'h0000});
      exp_q.push_back(32'h55);
`ifdef WB_TRACE_PC_WORD_EN
      exp_q.push_back(32'h304);
`endif
      drive_evt(5'd12, 32'h55, 32'h304, 1'b0, 1'b0);
      wait_drain();
      checks++;
      if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin failures++; $display("FAIL rstmid_word: got %h want %h", o, e); end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      bus.wb_reg_write = 1'b0;
      bus.wb_dest      = 5'd0;
      bus.wb_data      = 32'd0;
      bus.wb_pc        = 32'd0;
      bus.trace_ready  = 1'b0;
      test_reset();
      test_single();
      test_zero();
      test_back_to_back();
      test_backpressure();
      test_overflow(10, 8'd2);
      test_full_pop();
      test_overflow(300, 8'd255);
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
